implication_arbiter: RTL and testbench

- Round-based arbiter that sequences one BCP (unit propagation) round for the solver.
- Collects implications from NUM_REQ clause evaluators over valid/ready handshakes and grants them round-robin.
- Forwards at most one implication per cycle to the conflict detector (var index, value, enable).
- Halts on a reported conflict; signals round completion to the solver.

---
 rtl/implication_arbiter.sv | 179 +++++++++++++++++
 tb/tb_implication_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/implication_arbiter.sv
// implication_arbiter
// Sequences one unit-propagation round for the solver. Clause evaluators
// offer implications over valid/ready handshakes; the arbiter grants them
// round-robin and forwards at most one per cycle to the conflict detector.
// A reported conflict freezes the round until the solver clears it. A run of
// quiet cycles ends the round with a one-cycle done pulse.
//
// Ports:
//   clock, reset        system clock; asynchronous active-low reset
//   start, clear        solver pulses: begin a round / abort or acknowledge
//   req_valid/var/val   per-requester implication offers (var packed by index)
//   req_ready           one-hot grant back to the requesters
//   cd_var_idx/val/en   registered implication to the conflict detector
//   cd_conflict         conflict flag, meaningful while cd_en is high
//   busy, done          round running / round finished without conflict
//   conflict_out        level while the arbiter sits in the conflict state
//   issued_count        implications accepted this round (saturating)

module implication_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int VAR_BITS     = 9,
  parameter int QUIET_CYCLES = 2
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        clear,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*VAR_BITS-1:0] req_var,
  input  logic [NUM_REQ-1:0]          req_val,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic [VAR_BITS-1:0]         cd_var_idx,
  output logic                        cd_val,
  output logic                        cd_en,
  input  logic                        cd_conflict,
  output logic                        busy,
  output logic                        done,
  output logic                        conflict_out,
  output logic [15:0]                 issued_count
);

  localparam int PTR_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StConflict,
    StDone
  } state_e;

  state_e              state_q;
  logic [PTR_W-1:0]    rrPtr_q;
  logic [3:0]          quietCnt_q;
  logic [VAR_BITS-1:0] cdVar_q;
  logic                cdVal_q;
  logic                cdEn_q;
  logic                busy_q;
  logic                done_q;
  logic                conflict_q;
  logic [15:0]         issuedCount_q;

  logic                winnerFound;
  logic [PTR_W-1:0]    winnerIdx;
  logic [PTR_W-1:0]    candIdx;
  logic [VAR_BITS-1:0] winnerVar;
  logic                winnerVal;
  logic                grantValid;
  logic                quietHit;
  logic                quietDone;
  logic                conflictHit;
  logic [3:0]          quietCnt_d;
  logic [PTR_W-1:0]    rrPtr_d;
  logic [15:0]         issuedCount_d;

  // Round-robin search: scan upward from the pointer, wrapping naturally
  // because NUM_REQ is a power of two; the first valid requester wins.
  always_comb begin
    winnerFound = 1'b0;
    winnerIdx   = '0;
    candIdx     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      candIdx = rrPtr_q + PTR_W'(k);
      if (!winnerFound && req_valid[candIdx]) begin
        winnerFound = 1'b1;
        winnerIdx   = candIdx;
      end
    end
  end

  // Grant qualification and next-value helpers. clear and an incoming
  // conflict both suppress the grant so nothing is accepted that would be lost.
  always_comb begin
    winnerVar     = req_var[int'(winnerIdx)*VAR_BITS +: VAR_BITS];
    winnerVal     = req_val[winnerIdx];
    grantValid    = (state_q == StRun) && !clear && !cd_conflict && winnerFound;
    req_ready     = grantValid ? (NUM_REQ'(1) << winnerIdx) : '0;
    quietHit      = (req_valid == '0) && !cdEn_q;
    quietCnt_d    = quietHit ? (quietCnt_q + 4'd1) : 4'd0;
    quietDone     = quietHit && (quietCnt_d == 4'(QUIET_CYCLES));
    conflictHit   = cdEn_q && cd_conflict;
    rrPtr_d       = winnerIdx + PTR_W'(1);
    issuedCount_d = (issuedCount_q == 16'hFFFF) ? issuedCount_q : (issuedCount_q + 16'd1);
  end

  // Round FSM with registered status outputs. cd_en defaults low every
  // cycle and is raised only by a transfer, giving a one-cycle strobe.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= StIdle;
      rrPtr_q       <= '0;
      quietCnt_q    <= '0;
      cdVar_q       <= '0;
      cdVal_q       <= 1'b0;
      cdEn_q        <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      conflict_q    <= 1'b0;
      issuedCount_q <= '0;
    end else begin
      cdEn_q <= 1'b0;
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (!clear && start) begin
            state_q       <= StRun;
            busy_q        <= 1'b1;
            issuedCount_q <= '0;
            quietCnt_q    <= '0;
          end
        end
        StRun: begin
          if (clear) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end else if (conflictHit) begin
            state_q    <= StConflict;
            busy_q     <= 1'b0;
            conflict_q <= 1'b1;
          end else begin
            quietCnt_q <= quietCnt_d;
            if (grantValid) begin
              cdVar_q       <= winnerVar;
              cdVal_q       <= winnerVal;
              cdEn_q        <= 1'b1;
              rrPtr_q       <= rrPtr_d;
              issuedCount_q <= issuedCount_d;
            end
            if (quietDone) begin
              state_q <= StDone;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        StConflict: begin
          if (clear) begin
            state_q    <= StIdle;
            conflict_q <= 1'b0;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign cd_var_idx   = cdVar_q;
  assign cd_val       = cdVal_q;
  assign cd_en        = cdEn_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign conflict_out = conflict_q;
  assign issued_count = issuedCount_q;

endmodule

// File: tb/tb_implication_arbiter.sv
// tb_implication_arbiter
// Randomised and directed stimulus against a behavioural round model.
// Each accepted implication is queued when it is granted; an independent
// monitor pops the queue whenever the DUT raises cd_en and compares payloads.

module tb_implication_arbiter;

  localparam int NUM_REQ      = 4;
  localparam int VAR_BITS     = 9;
  localparam int QUIET_CYCLES = 2;

  localparam int ST_IDLE     = 0;
  localparam int ST_RUN      = 1;
  localparam int ST_CONFLICT = 2;
  localparam int ST_DONE     = 3;

  logic                        clock = 1'b0;
  logic                        reset = 1'b0;
  logic                        start = 1'b0;
  logic                        clear = 1'b0;
  logic [NUM_REQ-1:0]          req_valid = '0;
  logic [NUM_REQ*VAR_BITS-1:0] req_var = '0;
  logic [NUM_REQ-1:0]          req_val = '0;
  logic [NUM_REQ-1:0]          req_ready;
  logic [VAR_BITS-1:0]         cd_var_idx;
  logic                        cd_val;
  logic                        cd_en;
  logic                        cd_conflict = 1'b0;
  logic                        busy;
  logic                        done;
  logic                        conflict_out;
  logic [15:0]                 issued_count;

  implication_arbiter #(
    .NUM_REQ     (NUM_REQ),
    .VAR_BITS    (VAR_BITS),
    .QUIET_CYCLES(QUIET_CYCLES)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .clear       (clear),
    .req_valid   (req_valid),
    .req_var     (req_var),
    .req_val     (req_val),
    .req_ready   (req_ready),
    .cd_var_idx  (cd_var_idx),
    .cd_val      (cd_val),
    .cd_en       (cd_en),
    .cd_conflict (cd_conflict),
    .busy        (busy),
    .done        (done),
    .conflict_out(conflict_out),
    .issued_count(issued_count)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [VAR_BITS-1:0] varIdx;
    logic                val;
  } impl_t;

  impl_t expQueue[$];
  int    checks = 0;
  int    fails  = 0;

  // Reference model of the round, expressed in the solver's terms.
  int    mState = ST_IDLE;
  int    mPtr   = 0;
  int    mCount = 0;
  int    mQuiet = 0;
  logic  mCdEn  = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic int pickWinner(input logic [NUM_REQ-1:0] valid, input int ptr);
    for (int k = 0; k < NUM_REQ; k++) begin
      int idx;
      idx = (ptr + k) % NUM_REQ;
      if (valid[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic modelReset();
    mState = ST_IDLE;
    mPtr   = 0;
    mCount = 0;
    mQuiet = 0;
    mCdEn  = 1'b0;
    expQueue.delete();
  endtask

  task automatic checkRegs();
    checkOutput("busy", 32'(busy), 32'(mState == ST_RUN));
    checkOutput("done", 32'(done), 32'(mState == ST_DONE));
    checkOutput("conflict_out", 32'(conflict_out), 32'(mState == ST_CONFLICT));
    checkOutput("issued_count", 32'(issued_count), 32'(mCount));
    checkOutput("cd_en", 32'(cd_en), 32'(mCdEn));
  endtask

  // One cycle: check registered outputs, drive inputs, check the grant,
  // then advance the model across the coming rising edge.
  task automatic applyStimulus(input logic st, input logic cl, input logic [NUM_REQ-1:0] valid,
                               input logic [NUM_REQ*VAR_BITS-1:0] vars, input logic [NUM_REQ-1:0] vals,
                               input logic conf);
    int w;
    logic [NUM_REQ-1:0] expReady;
    @(negedge clock);
    checkRegs();
    start       = st;
    clear       = cl;
    req_valid   = valid;
    req_var     = vars;
    req_val     = vals;
    cd_conflict = conf;
    #1;
    w        = -1;
    expReady = '0;
    if (mState == ST_RUN && !cl && !conf) begin
      w = pickWinner(valid, mPtr);
      if (w >= 0) expReady = NUM_REQ'(1) << w;
    end
    checkOutput("req_ready", 32'(req_ready), 32'(expReady));
    case (mState)
      ST_IDLE: begin
        if (!cl && st) begin
          mState = ST_RUN;
          mCount = 0;
          mQuiet = 0;
        end
      end
      ST_RUN: begin
        if (cl) mState = ST_IDLE;
        else if (mCdEn && conf) mState = ST_CONFLICT;
        else begin
          if (valid == '0 && !mCdEn) mQuiet++;
          else mQuiet = 0;
          if (w >= 0) begin
            expQueue.push_back({vars[w*VAR_BITS +: VAR_BITS], vals[w]});
            mPtr = (w + 1) % NUM_REQ;
            if (mCount < 65535) mCount++;
          end
          if (mQuiet == QUIET_CYCLES) mState = ST_DONE;
        end
      end
      ST_CONFLICT: begin
        if (cl) mState = ST_IDLE;
      end
      default: mState = ST_IDLE;
    endcase
    mCdEn = (w >= 0);
  endtask

  task automatic idleSteps(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, '0, '0, '0, 1'b0);
  endtask

  task automatic resetPulse();
    @(negedge clock);
    reset = 1'b0;
    start = 1'b0; clear = 1'b0; req_valid = '0; cd_conflict = 1'b0;
    modelReset();
    @(negedge clock);
    reset = 1'b1;
  endtask

  // Drops reset between edges while an implication is on the cd_* bus.
  task automatic asyncResetMidRun();
    @(posedge clock);
    #3;
    checkOutput("pre_reset_cd_en", 32'(cd_en), 32'(mCdEn));
    reset = 1'b0;
    #1;
    checkOutput("async_cd_en", 32'(cd_en), 32'd0);
    checkOutput("async_busy", 32'(busy), 32'd0);
    checkOutput("async_issued_count", 32'(issued_count), 32'd0);
    checkOutput("async_req_ready", 32'(req_ready), 32'd0);
    start = 1'b0; clear = 1'b0; req_valid = '0; cd_conflict = 1'b0;
    modelReset();
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
  endtask

  // Monitor: whenever the DUT presents an implication, it must be the oldest
  // one the model saw granted.
  initial begin
    impl_t e;
    forever begin
      @(posedge clock);
      #2;
      if (reset === 1'b1 && cd_en === 1'b1) begin
        if (expQueue.size() == 0) begin
          checkOutput("cd_en_unexpected", 32'(cd_en), 32'd0);
        end else begin
          e = expQueue.pop_front();
          checkOutput("cd_var_idx", 32'(cd_var_idx), 32'(e.varIdx));
          checkOutput("cd_val", 32'(cd_val), 32'(e.val));
        end
      end
    end
  end

  initial begin
    logic [NUM_REQ*VAR_BITS-1:0] vars;
    logic st, cl, conf;
    logic [NUM_REQ-1:0] valid;

    // Reset held with every requester asserting valid.
    reset     = 1'b0;
    req_valid = 4'hF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      checkOutput("rst_req_ready", 32'(req_ready), 32'd0);
      checkOutput("rst_cd_en", 32'(cd_en), 32'd0);
      checkOutput("rst_done", 32'(done), 32'd0);
      checkOutput("rst_conflict_out", 32'(conflict_out), 32'd0);
      checkOutput("rst_issued_count", 32'(issued_count), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
    end
    req_valid = '0;
    reset     = 1'b1;

    // Single request from requester 2.
    applyStimulus(1'b1, 1'b0, '0, '0, '0, 1'b0);
    vars = '0;
    vars[2*VAR_BITS +: VAR_BITS] = 9'd5;
    applyStimulus(1'b0, 1'b0, 4'b0100, vars, 4'b0100, 1'b0);
    checkOutput("single_grant", 32'(req_ready), 32'h4);
    applyStimulus(1'b0, 1'b0, '0, '0, '0, 1'b0);
    checkOutput("single_cd_en", 32'(cd_en), 32'd1);
    checkOutput("single_cd_var", 32'(cd_var_idx), 32'd5);
    checkOutput("single_cd_val", 32'(cd_val), 32'd1);
    idleSteps(4);
    checkOutput("single_count", 32'(issued_count), 32'd1);
    checkOutput("single_busy_after", 32'(busy), 32'd0);

    // Round-robin sweep from pointer 0 with all requesters active.
    resetPulse();
    applyStimulus(1'b1, 1'b0, '0, '0, '0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      vars = '0;
      for (int r = 0; r < NUM_REQ; r++) vars[r*VAR_BITS +: VAR_BITS] = VAR_BITS'(10*i + r);
      applyStimulus(1'b0, 1'b0, 4'hF, vars, 4'b1010, 1'b0);
      checkOutput("rr_grant", 32'(req_ready), 32'(1 << (i % NUM_REQ)));
      if (i > 0) checkOutput("rr_cd_en", 32'(cd_en), 32'd1);
    end
    applyStimulus(1'b0, 1'b0, '0, '0, '0, 1'b0);
    checkOutput("rr_count", 32'(issued_count), 32'd5);
    idleSteps(5);

    // Conflict on variable 7 with requesters 0 and 1 still asserting.
    applyStimulus(1'b1, 1'b0, '0, '0, '0, 1'b0);
    vars = '0;
    vars[0 +: VAR_BITS]        = 9'd3;
    vars[VAR_BITS +: VAR_BITS] = 9'd7;
    applyStimulus(1'b0, 1'b0, 4'b0011, vars, 4'b0001, 1'b0);
    applyStimulus(1'b0, 1'b0, 4'b0011, vars, 4'b0001, 1'b1);
    checkOutput("conf_cd_var", 32'(cd_var_idx), 32'd7);
    checkOutput("conf_ready", 32'(req_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 4'b0011, vars, 4'b0001, 1'b0);
      checkOutput("conf_level", 32'(conflict_out), 32'd1);
      checkOutput("conf_no_cd_en", 32'(cd_en), 32'd0);
    end
    applyStimulus(1'b0, 1'b1, 4'b0011, vars, 4'b0001, 1'b0);
    applyStimulus(1'b0, 1'b0, '0, '0, '0, 1'b0);
    checkOutput("conf_cleared", 32'(conflict_out), 32'd0);
    checkOutput("conf_count_kept", 32'(issued_count), 32'd1);

    // Precedence and ignored inputs.
    applyStimulus(1'b1, 1'b1, '0, '0, '0, 1'b0);
    applyStimulus(1'b0, 1'b0, 4'hF, '0, '0, 1'b0);
    checkOutput("clear_over_start", 32'(busy), 32'd0);
    checkOutput("idle_ready", 32'(req_ready), 32'd0);
    applyStimulus(1'b1, 1'b0, 4'hF, '0, '0, 1'b0);
    applyStimulus(1'b0, 1'b0, 4'hF, '0, '0, 1'b0);
    applyStimulus(1'b1, 1'b0, 4'hF, '0, '0, 1'b0);
    applyStimulus(1'b0, 1'b0, 4'hF, '0, '0, 1'b0);
    checkOutput("start_in_run_ignored", 32'(issued_count), 32'd2);
    checkOutput("still_busy", 32'(busy), 32'd1);
    applyStimulus(1'b0, 1'b0, 4'hF, '0, '0, 1'b0);
    asyncResetMidRun();

    // Randomised rounds.
    for (int i = 0; i < 1500; i++) begin
      st    = (mState == ST_IDLE) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
      cl    = (mState == ST_CONFLICT) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 39) == 0);
      valid = ($urandom_range(0, 2) == 0) ? '0 : NUM_REQ'($urandom);
      vars  = (NUM_REQ*VAR_BITS)'({$urandom, $urandom});
      conf  = mCdEn && ($urandom_range(0, 11) == 0);
      applyStimulus(st, cl, valid, vars, NUM_REQ'($urandom), conf);
    end
    idleSteps(6);
    checkOutput("queue_drained", 32'(expQueue.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
